// File: rtl/chip_pkg.sv
// Shared constants and state encoding for the chip sample frame buffer.
package chip_pkg;

  localparam int LEN_CHIP = 3999;  // samples per chip frame
  localparam int CHIP_AW  = 12;    // buffer address width
  localparam int CHIP_DW  = 16;    // sample width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2,
    READ = 2'd3
  } chip_state_t;

endpackage

// File: rtl/chip_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// No reset so that it maps onto block RAM.
module chip_ram #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic          clk_sys,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_q;

  // Write port: store the sample at the write address.
  always_ff @(posedge clk_sys) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read port: one-cycle registered read, only updated on a read request.
  always_ff @(posedge clk_sys) begin
    if (i_re) r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/chip_buf.sv
// Chip frame buffer: collects LEN samples from the chip path, then lets the
// reader pop them once in order before accepting the next frame.
module chip_buf
  import chip_pkg::*;
#(
  parameter int LEN = LEN_CHIP,
  parameter int AW  = CHIP_AW
) (
  input  logic               clk_sys,
  input  logic               rst,
  input  logic [CHIP_DW-1:0] d1_data,
  input  logic               d1_vld,
  output logic               buf_rdy,
  input  logic               rd_en,
  output logic [CHIP_DW-1:0] rd_data,
  output logic               rd_vld,
  output logic               chip_done,
  input  logic               cfg_flush,
  output logic [15:0]        chip_cnt,
  output logic [15:0]        drop_cnt
);

  // Pointers need one extra bit so that LEN = 2^AW is representable.
  localparam int            PW       = AW + 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(LEN - 1);

  chip_state_t        r_state;
  chip_state_t        w_state_next;
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic               r_buf_rdy;
  logic               r_rd_vld;
  logic [CHIP_DW-1:0] r_rd_hold;
  logic [CHIP_DW-1:0] w_ram_q;
  logic [15:0]        r_chip_cnt;
  logic [15:0]        r_drop_cnt;
  logic               w_wr_fire;
  logic               w_rd_fire;
  logic               w_rd_last;

  // State register.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next state plus write/read strobes; flush overrides everything.
  always_comb begin
    w_state_next = r_state;
    w_wr_fire    = 1'b0;
    w_rd_fire    = 1'b0;
    w_rd_last    = 1'b0;
    if (cfg_flush) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (d1_vld && r_buf_rdy) begin
            w_wr_fire    = 1'b1;
            w_state_next = (LEN == 1) ? FULL : FILL;
          end
        end
        FILL: begin
          if (d1_vld && r_buf_rdy) begin
            w_wr_fire = 1'b1;
            if (r_wr_ptr == LAST_IDX) w_state_next = FULL;
          end
        end
        FULL, READ: begin
          if (rd_en) begin
            w_rd_fire    = 1'b1;
            w_rd_last    = (r_rd_ptr == LAST_IDX);
            w_state_next = w_rd_last ? IDLE : READ;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Write and read pointers; the final read of a frame rewinds both.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (cfg_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_fire) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd_last) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else if (w_rd_fire) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  // Registered ready (follows the next state) and read-valid strobe.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      r_buf_rdy <= 1'b0;
      r_rd_vld  <= 1'b0;
    end else begin
      r_buf_rdy <= (w_state_next == IDLE) || (w_state_next == FILL);
      r_rd_vld  <= w_rd_fire;
    end
  end

  // Remember the last delivered word so rd_data holds between pops.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst)           r_rd_hold <= '0;
    else if (r_rd_vld) r_rd_hold <= w_ram_q;
  end

  // Completed-frame counter (wrapping) and dropped-sample counter (saturating).
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      r_chip_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if ((w_state_next == FULL) && (r_state != FULL))
        r_chip_cnt <= r_chip_cnt + 16'd1;
      if (cfg_flush)
        r_drop_cnt <= '0;
      else if (d1_vld && !r_buf_rdy && (r_drop_cnt != 16'hFFFF))
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  chip_ram #(
    .AW (AW),
    .DW (CHIP_DW)
  ) u_ram (
    .clk_sys (clk_sys),
    .i_we    (w_wr_fire),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (d1_data),
    .i_re    (w_rd_fire),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_ram_q)
  );

  assign buf_rdy   = r_buf_rdy;
  assign rd_vld    = r_rd_vld;
  assign rd_data   = r_rd_vld ? w_ram_q : r_rd_hold;
  assign chip_done = (r_state == FULL) || (r_state == READ);
  assign chip_cnt  = r_chip_cnt;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_chip_buf.sv
// Bench for chip_buf with a 10-sample frame. A frame-level model (a queue of
// stored samples) predicts ready/done/counters; every popped word is pushed
// to a scoreboard queue and checked by an independent monitor.
module tb_chip_buf;

  localparam int LEN = 10;

  logic        clk_sys   = 1'b0;
  logic        rst       = 1'b1;
  logic [15:0] d1_data   = '0;
  logic        d1_vld    = 1'b0;
  logic        rd_en     = 1'b0;
  logic        cfg_flush = 1'b0;
  logic        buf_rdy;
  logic [15:0] rd_data;
  logic        rd_vld;
  logic        chip_done;
  logic [15:0] chip_cnt;
  logic [15:0] drop_cnt;

  chip_buf #(.LEN(LEN), .AW(4)) dut (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .d1_data   (d1_data),
    .d1_vld    (d1_vld),
    .buf_rdy   (buf_rdy),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_vld    (rd_vld),
    .chip_done (chip_done),
    .cfg_flush (cfg_flush),
    .chip_cnt  (chip_cnt),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];      // scoreboard: words the reader should see
  logic [15:0] m_frame[$];    // model: samples currently held
  int          m_reads;       // model: words already popped from the frame
  bit          m_rdy;         // model: buffer accepting samples
  int unsigned m_chip;
  int unsigned m_drop;
  logic [15:0] m_last = '0;   // last word delivered to the reader
  int          vld_pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Frame-level rules: accept until LEN samples held, otherwise drop;
  // a complete frame is popped in order once, then the buffer empties.
  task automatic step(input bit vld, input logic [15:0] d, input bit rd, input bit fl);
    d1_vld = vld; d1_data = d; rd_en = rd; cfg_flush = fl;
    if (fl) begin
      m_frame.delete(); m_reads = 0; m_drop = 0;
    end else if (m_rdy) begin
      if (vld) begin
        m_frame.push_back(d);
        if (m_frame.size() == LEN) m_chip = (m_chip + 1) % 65536;
      end
    end else begin
      if (vld && m_drop < 65535) m_drop++;
      if (rd && m_frame.size() == LEN) begin
        exp_q.push_back(m_frame[m_reads]);
        m_reads++;
        if (m_reads == LEN) begin
          m_frame.delete(); m_reads = 0;
        end
      end
    end
    m_rdy = (m_frame.size() < LEN);
    @(posedge clk_sys); #1;
    chk("buf_rdy", buf_rdy, m_rdy);
    chk("chip_done", chip_done, m_frame.size() == LEN);
    chk("chip_cnt", chip_cnt, m_chip);
    chk("drop_cnt", drop_cnt, m_drop);
  endtask

  task automatic reset_checks(input string tag);
    $display("reset check %s", tag);
    chk("rst_buf_rdy", buf_rdy, 0);
    chk("rst_rd_vld", rd_vld, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_chip_done", chip_done, 0);
    chk("rst_chip_cnt", chip_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
  endtask

  task automatic model_reset();
    m_frame.delete(); exp_q.delete();
    m_reads = 0; m_rdy = 1'b0; m_chip = 0; m_drop = 0; m_last = '0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < LEN; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0);
  endtask

  task automatic read_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
  endtask

  // Monitor: pops the scoreboard on every rd_vld, checks hold otherwise.
  always @(negedge clk_sys) begin
    if (!rst) begin
      checks++;
      if (rd_vld) begin
        vld_pulses++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rd_vld_unexpected actual_data=%h expected=none", rd_data);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          $display("pop data=%h expected=%h", rd_data, e);
          if (rd_data !== e) begin
            errors++;
            $display("FAIL rd_data actual=%h expected=%h", rd_data, e);
          end
          m_last = e;
        end
      end else if (rd_data !== m_last) begin
        errors++;
        $display("FAIL rd_data_hold actual=%h expected=%h", rd_data, m_last);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk_sys);
    #1;
    reset_checks("power_on");
    rst = 1'b0;
    step(1'b0, 16'h0, 1'b0, 1'b0);

    // Ramp 1..10 every cycle, then read it back.
    for (int i = 1; i <= LEN; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    read_n(LEN);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("chip_cnt_ramp", chip_cnt, 1);

    // Frame delivered with d1_vld toggling.
    for (int i = 0; i < 2 * LEN; i++) step(i % 2 == 0, 16'($urandom), 1'b0, 1'b0);
    read_n(LEN);

    // Three samples offered while full are dropped.
    fill_random();
    for (int i = 0; i < 3; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0);
    chk("drop_cnt_three", drop_cnt, 3);
    read_n(LEN);

    // Flush a partial frame, then a fresh frame.
    for (int i = 0; i < 5; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0);
    step(1'b1, 16'hDEAD, 1'b1, 1'b1);
    chk("drop_cnt_flush", drop_cnt, 0);
    fill_random();
    read_n(LEN);

    // Over-read: 12 requests, 10 words.
    fill_random();
    begin
      int base;
      base = vld_pulses;
      read_n(LEN + 2);
      step(1'b0, 16'h0, 1'b0, 1'b0);
      chk("rd_vld_pulses", vld_pulses - base, LEN);
      chk("idle_after_read", chip_done, 0);
    end

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++)
      step(1'($urandom), 16'($urandom), 1'($urandom), ($urandom % 50) == 0);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("queue_drained_random", exp_q.size(), 0);

    // Reset in the middle of a read-out.
    fill_random();
    read_n(4);
    rst = 1'b1;
    #1;
    reset_checks("mid_read");
    model_reset();
    @(posedge clk_sys); #1;
    rst = 1'b0;
    step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("buf_rdy_after_reset", buf_rdy, 1);
    fill_random();
    read_n(LEN);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("queue_drained_end", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chip_buf.md
CHIP_BUF -- requirements
Module: chip_buf

Interface
REQ-001 Parameter LEN, default 3999: samples per chip frame, which is the upstream window length minus one; legal range 1..4096.
REQ-002 Parameter AW, default 12: buffer address width; LEN SHALL NOT exceed 2^AW.
REQ-003 Port clk_sys  input  1  system clock; the only clock in the block.
REQ-004 Port rst  input  1  asynchronous active-high reset.
REQ-005 Port d1_data  input  16  chip sample from the chip path.
REQ-006 Port d1_vld  input  1  sample valid from the chip path.
REQ-007 Port buf_rdy  output  1  buffer accepts samples; returned to the chip path.
REQ-008 Port rd_en  input  1  reader pop request, one word per cycle.
REQ-009 Port rd_data  output  16  popped word.
REQ-010 Port rd_vld  output  1  rd_data valid.
REQ-011 Port chip_done  output  1  a complete frame is held and readable.
REQ-012 Port cfg_flush  input  1  synchronous abort and clear.
REQ-013 Port chip_cnt  output  16  count of completed frames, wrapping.
REQ-014 Port drop_cnt  output  16  samples dropped while buf_rdy=0, saturating.

Function
REQ-015 The block SHALL implement states IDLE, FILL, FULL and READ.
REQ-016 A write SHALL occur on any cycle where d1_vld=1 and buf_rdy=1; the word goes to address wr_ptr and wr_ptr increments.
REQ-017 buf_rdy SHALL be 1 in IDLE and FILL, and 0 in FULL and READ; it is registered.
REQ-018 IDLE->FILL SHALL occur on the first write (wr_ptr becomes 1).
REQ-019 FILL->FULL SHALL occur on the write that makes wr_ptr=LEN; buf_rdy SHALL be 0 from the next cycle.
REQ-020 If LEN=1, IDLE->FULL SHALL occur directly on the first write.
REQ-021 Gaps in d1_vld during FILL SHALL NOT abort the frame; FILL has no timeout.
REQ-022 chip_done SHALL be 1 in FULL and READ, and 0 otherwise.
REQ-023 chip_cnt SHALL increment, mod 2^16, on entry to FULL.
REQ-024 FULL->READ SHALL occur on the first rd_en.
REQ-025 In FULL or READ, rd_en=1 SHALL read address rd_ptr and increment rd_ptr; rd_data and rd_vld SHALL be valid exactly 1 cycle later.
REQ-026 rd_en SHALL be ignored in IDLE and FILL (rd_vld stays 0) and ignored after the LEN-th read.
REQ-027 The read that makes rd_ptr=LEN SHALL move READ->IDLE, clear wr_ptr and rd_ptr, and make buf_rdy=1 on the next cycle; the last rd_vld pulse is still delivered.
REQ-028 Samples with d1_vld=1 and buf_rdy=0 SHALL be discarded and SHALL increment drop_cnt, saturating at 0xFFFF.
REQ-029 drop_cnt SHALL clear only on rst or cfg_flush.
REQ-030 cfg_flush=1 SHALL, in any state, force IDLE and clear wr_ptr, rd_ptr and drop_cnt on the next cycle.
REQ-031 cfg_flush has priority over a simultaneous write or read; rd_vld SHALL be 0 the cycle after the flush.
REQ-032 chip_cnt SHALL be unaffected by cfg_flush.
REQ-033 A simultaneous write and read is impossible by state and needs no arbitration.
REQ-034 rd_data SHALL hold its last value when rd_vld=0.

Reset
REQ-035 On rst=1, asynchronously: state=IDLE, wr_ptr=0, rd_ptr=0, buf_rdy=0, rd_vld=0, rd_data=0, chip_done=0, chip_cnt=0, drop_cnt=0.
REQ-036 buf_rdy SHALL rise the first clk_sys edge after rst deasserts.
REQ-037 Reset mid-frame SHALL discard the partial frame; RAM contents are not cleared.

Structure
REQ-038 Shared package chip_pkg SHALL hold LEN_CHIP (3999), CHIP_AW (12), CHIP_DW (16) and the state encoding.
REQ-039 Storage SHALL be a separate sub-module chip_ram: simple dual-port, 2^AW x 16, synchronous read with 1-cycle latency, no reset, inferable as block RAM.
REQ-040 All control logic SHALL reside in chip_buf.

Verification (LEN=10 for the bench)
REQ-041 Ramp 1..10 on d1_vld every cycle, then 10 rd_en pulses -> rd_data=1..10 with 1-cycle latency, chip_cnt=1, buf_rdy low from the cycle after sample 10 until after the 10th read.
REQ-042 Frame sent with d1_vld toggling 1/0 -> frame completes after 10 valid samples; readback matches.
REQ-043 Three d1_vld pulses while FULL -> drop_cnt=3 and the stored data is unchanged.
REQ-044 cfg_flush after 5 writes, then a fresh 10-sample frame -> readback equals the fresh frame only; drop_cnt=0; chip_cnt=1.
REQ-045 12 rd_en pulses against a full frame -> exactly 10 rd_vld pulses; the state returns to IDLE.
REQ-046 rst asserted mid-READ -> all outputs at their reset values immediately; buf_rdy=1 one cycle after release.
